// File: rtl/weights_pkg.sv
// Shared constants and state type for the weights memory loader.
package weights_pkg;
  localparam int WEIGHTS_ADDR_W = 13;
  localparam int WEIGHTS_DATA_W = 16;
  localparam int WEIGHTS_DEPTH  = 8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;
endpackage

// File: rtl/weights_loader.sv
// Streams a range of weight words into memory port A with one registered write stage.
// Optional running checksum is enabled by defining WEIGHTS_LOADER_CHECKSUM_EN.
module weights_loader
  import weights_pkg::*;
#(
  parameter int ADDR_W = WEIGHTS_ADDR_W,
  parameter int DATA_W = WEIGHTS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_select,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);
  // 2^ADDR_W in a width that can hold base_addr + word_count without overflow
  localparam logic [ADDR_W+1:0] SPAN = {2'b01, {ADDR_W{1'b0}}};

  loader_state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q, idx_q, idx_nxt;
  logic [ADDR_W+1:0] end_addr;
  logic              start_acc, range_err, accept, last_word;

  assign start_acc = (state == IDLE) && start;
  assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};
  assign range_err = end_addr > SPAN;
  assign accept    = (state == LOAD) && in_valid;
  assign idx_nxt   = idx_q + (ADDR_W+1)'(1);
  assign last_word = (idx_nxt == count_q);

  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign mem_select = ~busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
        if (word_count == '0) state_nxt = DONE;
        else if (!range_err)  state_nxt = LOAD;
      end
      LOAD:    if (accept && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      error       <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      mem_wren <= accept;
      if (start_acc) begin
        base_q  <= base_addr;
        count_q <= word_count;
        idx_q   <= '0;
        error   <= range_err;
      end
      if (accept) begin
        // range check at start guarantees base_q + idx_q never wraps
        mem_address <= base_q + idx_q[ADDR_W-1:0];
        mem_data    <= in_data;
        idx_q       <= idx_nxt;
      end
    end
  end

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (accept)    checksum <= checksum + in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weights_loader.sv
// Directed self-checking bench for weights_loader.
module tb_weights_loader;
  import weights_pkg::*;

  localparam int AW = WEIGHTS_ADDR_W;
  localparam int DW = WEIGHTS_DATA_W;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic          mem_select;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  weights_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_select(mem_select), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".wren"}, 32'(mem_wren), 0);
    chk({tag, ".addr"}, 32'(mem_address), 0);
    chk({tag, ".data"}, 32'(mem_data), 0);
    chk({tag, ".select"}, 32'(mem_select), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".error"}, 32'(error), 0);
    chk({tag, ".checksum"}, 32'(checksum), 0);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    tick();
    start = 1'b0;
  endtask

  // present one word, then check the registered write it produces
  task automatic xfer(input string tag, input logic [DW-1:0] d,
                      input logic [AW-1:0] exp_addr, input logic exp_done);
    in_valid = 1'b1; in_data = d;
    chk({tag, ".ready"}, 32'(in_ready), 1);
    tick();
    chk({tag, ".wren"}, 32'(mem_wren), 1);
    chk({tag, ".addr"}, 32'(mem_address), 32'(exp_addr));
    chk({tag, ".data"}, 32'(mem_data), 32'(d));
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_data = '0; in_valid = 1'b0;
    tick(); tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    // four back-to-back words
    do_start(13'h0010, 14'd4);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.select", 32'(mem_select), 0);
    chk("t1.wren0", 32'(mem_wren), 0);
    xfer("t1.w0", 16'h1111, 13'h0010, 1'b0);
    xfer("t1.w1", 16'h2222, 13'h0011, 1'b0);
    xfer("t1.w2", 16'h3333, 13'h0012, 1'b0);
    xfer("t1.w3", 16'h4444, 13'h0013, 1'b1);
    chk("t1.ready_drop", 32'(in_ready), 0);
    chk("t1.cksum", 32'(checksum), CK_EN ? 32'hAAAA : 32'h0);
    tick();
    chk("t1.done_low", 32'(done), 0);
    chk("t1.wren_end", 32'(mem_wren), 0);
    chk("t1.idle_busy", 32'(busy), 0);
    chk("t1.idle_sel", 32'(mem_select), 1);
    in_valid = 1'b0;

    // stalls 1,0,0,1
    do_start(13'h0100, 14'd2);
    chk("t2.cksum_clr", 32'(checksum), 0);
    xfer("t2.w0", 16'hA5A5, 13'h0100, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("t2.stall1", 32'(mem_wren), 0);
    tick();
    chk("t2.stall2", 32'(mem_wren), 0);
    chk("t2.stall_busy", 32'(busy), 1);
    xfer("t2.w1", 16'h5A5A, 13'h0101, 1'b1);
    chk("t2.cksum", 32'(checksum), CK_EN ? 32'hFFFF : 32'h0);
    in_valid = 1'b0;
    tick();

    // out-of-range request
    do_start(13'h1FFE, 14'd3);
    chk("t3.error", 32'(error), 1);
    chk("t3.busy", 32'(busy), 0);
    chk("t3.select", 32'(mem_select), 1);
    in_valid = 1'b1; in_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("t3.ready", 32'(in_ready), 0);
      tick();
      chk("t3.wren", 32'(mem_wren), 0);
    end
    in_valid = 1'b0;
    chk("t3.sticky", 32'(error), 1);

    // exact fit at the top of memory; start clears error
    do_start(13'h1FFE, 14'd2);
    chk("t4.err_clr", 32'(error), 0);
    xfer("t4.w0", 16'h0001, 13'h1FFE, 1'b0);
    xfer("t4.w1", 16'h0002, 13'h1FFF, 1'b1);
    in_valid = 1'b0;
    tick();

    // zero-length request
    do_start(13'h0200, 14'd0);
    chk("t5.done", 32'(done), 1);
    chk("t5.busy", 32'(busy), 1);
    chk("t5.wren", 32'(mem_wren), 0);
    chk("t5.error", 32'(error), 0);
    chk("t5.ready", 32'(in_ready), 0);
    tick();
    chk("t5.done_low", 32'(done), 0);
    chk("t5.busy_low", 32'(busy), 0);

    // start re-pulsed mid-load is ignored
    do_start(13'h0020, 14'd3);
    xfer("t6.w0", 16'h0101, 13'h0020, 1'b0);
    start = 1'b1; base_addr = 13'h0040; word_count = 14'd1;
    xfer("t6.w1", 16'h0202, 13'h0021, 1'b0);
    start = 1'b0;
    xfer("t6.w2", 16'h0303, 13'h0022, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("t6.idle", 32'(busy), 0);

    // reset mid-load
    do_start(13'h0030, 14'd5);
    xfer("t7.w0", 16'h00B0, 13'h0030, 1'b0);
    xfer("t7.w1", 16'h00B1, 13'h0031, 1'b0);
    in_data = 16'h00B2;
    #2 rst = 1'b1;
    #1 chk_reset_outs("t7.rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7.no_wren", 32'(mem_wren), 0);
      chk("t7.no_done", 32'(done), 0);
    end
    in_valid = 1'b0;
    do_start(13'h0050, 14'd1);
    xfer("t7.reload", 16'h00CC, 13'h0050, 1'b1);
    in_valid = 1'b0;
    tick();

    // full-range load; checksum = sum(0..8191) mod 2^16 = 0xF000
    do_start(13'h0000, 14'd8192);
    for (int i = 0; i < WEIGHTS_DEPTH; i++)
      xfer("t8", DW'(i), AW'(i), (i == WEIGHTS_DEPTH-1));
    chk("t8.cksum", 32'(checksum), CK_EN ? 32'hF000 : 32'h0);
    in_valid = 1'b0;
    tick();
    chk("t8.idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
